// File: rtl/vote_pkg.sv
// Shared types and sizing for the plurality vote tally datapath.
package vote_pkg;

  localparam int unsigned NUM_VOTERS = 8;
  localparam int unsigned BALLOT_W   = 2;
  localparam int unsigned NUM_CAND   = 2 ** BALLOT_W;
  localparam int unsigned CNT_W      = $clog2(NUM_VOTERS + 1);

  typedef logic [BALLOT_W-1:0] ballot_t;
  typedef logic [CNT_W-1:0]    count_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_SCAN    = 2'd2,
    ST_DONE    = 2'd3
  } vote_state_e;

endpackage

// File: rtl/vote_counter_bank.sv
// One vote counter per candidate code, with a combinational read port for the scan.
module vote_counter_bank
  import vote_pkg::*;
(
  input  logic    clk,
  input  logic    rst_n,
  input  logic    clr,
  input  logic    inc,
  input  ballot_t inc_idx,
  input  ballot_t rd_idx,
  output count_t  rd_cnt_c
);

  count_t cnt [NUM_CAND];

  // Clear has priority so a restart never keeps a ballot from the old election.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_CAND); i++) cnt[i] <= '0;
    end else if (clr) begin
      for (int i = 0; i < int'(NUM_CAND); i++) cnt[i] <= '0;
    end else if (inc) begin
      cnt[inc_idx] <= cnt[inc_idx] + count_t'(1);
    end
  end

  assign rd_cnt_c = cnt[rd_idx];

endmodule

// File: rtl/vote_tally_seq.sv
// Serial ballot collector: counts ballots, scans counts one candidate per cycle, holds the winner.
module vote_tally_seq
  import vote_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                close_i,
  input  logic                ballot_valid_i,
  input  logic [BALLOT_W-1:0] ballot_i,
  output logic                ballot_ready_o,
  output logic                busy_o,
  output logic [CNT_W-1:0]    ballots_o,
  output logic                result_valid_o,
  output logic [BALLOT_W-1:0] winner_o,
  output logic [CNT_W-1:0]    winner_cnt_o,
  output logic                tie_o
);

  vote_state_e state, state_d;
  ballot_t     idx, idx_d;
  count_t      max_cnt, max_cnt_d;
  ballot_t     max_win, max_win_d;
  logic        max_tie, max_tie_d;

  count_t      ballots_d, wcnt_d;
  ballot_t     winner_d;
  logic        valid_d, tie_d, ready_d, busy_d;

  logic        clr, inc, accept;
  count_t      rd_cnt;
  count_t      scan_cnt;
  ballot_t     scan_win;
  logic        scan_tie;

  vote_counter_bank u_bank (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr),
    .inc      (inc),
    .inc_idx  (ballot_i),
    .rd_idx   (idx),
    .rd_cnt_c (rd_cnt)
  );

  assign accept = ballot_valid_i && ballot_ready_o;

  // One scan step: strict greater-than keeps the lower code on ties.
  always_comb begin
    scan_cnt = max_cnt;
    scan_win = max_win;
    scan_tie = max_tie;
    if (idx == '0) begin
      scan_cnt = rd_cnt;
      scan_win = idx;
      scan_tie = 1'b0;
    end else if (rd_cnt > max_cnt) begin
      scan_cnt = rd_cnt;
      scan_win = idx;
      scan_tie = 1'b0;
    end else if (rd_cnt == max_cnt) begin
      scan_tie = 1'b1;
    end
  end

  always_comb begin
    state_d   = state;
    idx_d     = idx;
    max_cnt_d = max_cnt;
    max_win_d = max_win;
    max_tie_d = max_tie;
    ballots_d = ballots_o;
    valid_d   = result_valid_o;
    winner_d  = winner_o;
    wcnt_d    = winner_cnt_o;
    tie_d     = tie_o;
    clr       = 1'b0;
    inc       = 1'b0;

    if (start_i) begin
      state_d   = ST_COLLECT;
      clr       = 1'b1;
      idx_d     = '0;
      ballots_d = '0;
      valid_d   = 1'b0;
      winner_d  = '0;
      wcnt_d    = '0;
      tie_d     = 1'b0;
    end else begin
      case (state)
        ST_COLLECT: begin
          if (accept) begin
            inc       = 1'b1;
            ballots_d = ballots_o + count_t'(1);
          end
          if (close_i || (accept && ballots_o == count_t'(NUM_VOTERS - 1))) begin
            state_d = ST_SCAN;
            idx_d   = '0;
          end
        end
        ST_SCAN: begin
          max_cnt_d = scan_cnt;
          max_win_d = scan_win;
          max_tie_d = scan_tie;
          idx_d     = idx + ballot_t'(1);
          if (idx == ballot_t'(NUM_CAND - 1)) begin
            state_d  = ST_DONE;
            valid_d  = 1'b1;
            winner_d = scan_win;
            wcnt_d   = scan_cnt;
            tie_d    = scan_tie;
          end
        end
        ST_DONE: state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end

    // Handshake flags are registered from the next-state view so they track state exactly.
    ready_d = (state_d == ST_COLLECT) && (ballots_d < count_t'(NUM_VOTERS));
    busy_d  = (state_d == ST_COLLECT) || (state_d == ST_SCAN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      idx            <= '0;
      max_cnt        <= '0;
      max_win        <= '0;
      max_tie        <= 1'b0;
      ballots_o      <= '0;
      result_valid_o <= 1'b0;
      winner_o       <= '0;
      winner_cnt_o   <= '0;
      tie_o          <= 1'b0;
      ballot_ready_o <= 1'b0;
      busy_o         <= 1'b0;
    end else begin
      state          <= state_d;
      idx            <= idx_d;
      max_cnt        <= max_cnt_d;
      max_win        <= max_win_d;
      max_tie        <= max_tie_d;
      ballots_o      <= ballots_d;
      result_valid_o <= valid_d;
      winner_o       <= winner_d;
      winner_cnt_o   <= wcnt_d;
      tie_o          <= tie_d;
      ballot_ready_o <= ready_d;
      busy_o         <= busy_d;
    end
  end

endmodule

// File: tb/tb_vote_tally_seq.sv
// Self-checking bench for vote_tally_seq: directed cases plus random elections against a tally model.
module tb_vote_tally_seq;
  import vote_pkg::*;

  logic    clk = 1'b0;
  logic    rst_n = 1'b0;
  logic    start_i = 1'b0;
  logic    close_i = 1'b0;
  logic    ballot_valid_i = 1'b0;
  ballot_t ballot_i = '0;
  logic    ballot_ready_o, busy_o, result_valid_o, tie_o;
  count_t  ballots_o, winner_cnt_o;
  ballot_t winner_o;

  int n_checks = 0;
  int n_errors = 0;

  vote_tally_seq dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_i        (start_i),
    .close_i        (close_i),
    .ballot_valid_i (ballot_valid_i),
    .ballot_i       (ballot_i),
    .ballot_ready_o (ballot_ready_o),
    .busy_o         (busy_o),
    .ballots_o      (ballots_o),
    .result_valid_o (result_valid_o),
    .winner_o       (winner_o),
    .winner_cnt_o   (winner_cnt_o),
    .tie_o          (tie_o)
  );

  always #5 clk = ~clk;

  // Election model: tallies, a collecting flag, a scan countdown and a done flag.
  int m_cnt [NUM_CAND] = '{default: 0};
  int m_ballots   = 0;
  bit m_collect   = 1'b0;
  int m_scan_left = 0;
  bit m_done      = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_ballots = 0; m_collect = 1'b0; m_scan_left = 0; m_done = 1'b0;
    end else if (start_i) begin
      foreach (m_cnt[i]) m_cnt[i] = 0;
      m_ballots = 0; m_collect = 1'b1; m_scan_left = 0; m_done = 1'b0;
    end else if (m_collect) begin
      if (ballot_valid_i && m_ballots < int'(NUM_VOTERS)) begin
        m_cnt[ballot_i] = m_cnt[ballot_i] + 1;
        m_ballots = m_ballots + 1;
      end
      if (close_i || m_ballots == int'(NUM_VOTERS)) begin
        m_collect = 1'b0;
        m_scan_left = int'(NUM_CAND);
      end
    end else if (m_scan_left > 0) begin
      m_scan_left = m_scan_left - 1;
      if (m_scan_left == 0) m_done = 1'b1;
    end
  end

  // Plurality winner: highest count, lowest code on equal counts.
  function automatic void model_result(output int w, output int c, output bit t);
    w = 0;
    for (int k = 1; k < int'(NUM_CAND); k++) if (m_cnt[k] > m_cnt[w]) w = k;
    c = m_cnt[w];
    t = 1'b0;
    for (int k = 0; k < int'(NUM_CAND); k++) if (k != w && m_cnt[k] == c) t = 1'b1;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int w, c;
    bit t;
    model_result(w, c, t);
    chk("ready",      int'(ballot_ready_o), int'(m_collect && m_ballots < int'(NUM_VOTERS)));
    chk("busy",       int'(busy_o),         int'(m_collect || m_scan_left > 0));
    chk("ballots",    int'(ballots_o),      m_ballots);
    chk("valid",      int'(result_valid_o), int'(m_done));
    chk("winner",     int'(winner_o),       m_done ? w : 0);
    chk("winner_cnt", int'(winner_cnt_o),   m_done ? c : 0);
    chk("tie",        int'(tie_o),          m_done ? int'(t) : 0);
  end

  task automatic drive(input bit s, input bit c, input bit v, input int b);
    start_i = s; close_i = c; ballot_valid_i = v; ballot_i = ballot_t'(b);
    @(posedge clk);
    #2;
  endtask

  // Idles until result_valid_o rises; lat is the number of edges waited.
  task automatic wait_result(output int lat);
    lat = -1;
    for (int i = 1; i <= 12; i++) begin
      drive(0, 0, 0, 0);
      if (result_valid_o) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) chk("result_timeout", 0, 1);
  endtask

  task automatic run_case1();
    int seq [8] = '{1, 1, 2, 3, 1, 0, 2, 1};
    int lat;
    drive(1, 0, 0, 0);
    foreach (seq[i]) drive(0, 0, 1, seq[i]);
    wait_result(lat);
    chk("c1_latency", lat, 4);
    chk("c1_winner", int'(winner_o), 1);
    chk("c1_cnt", int'(winner_cnt_o), 4);
    chk("c1_tie", int'(tie_o), 0);
  endtask

  initial begin
    int lat;
    int seq2 [8] = '{2, 2, 3, 3, 0, 1, 0, 1};

    @(negedge clk);
    #1;
    chk("rst_valid", int'(result_valid_o), 0);
    chk("rst_ready", int'(ballot_ready_o), 0);
    chk("rst_ballots", int'(ballots_o), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    drive(0, 0, 0, 0);

    run_case1();

    drive(1, 0, 0, 0);
    foreach (seq2[i]) drive(0, 0, 1, seq2[i]);
    wait_result(lat);
    chk("c2_latency", lat, 4);
    chk("c2_winner", int'(winner_o), 0);
    chk("c2_cnt", int'(winner_cnt_o), 2);
    chk("c2_tie", int'(tie_o), 1);

    drive(1, 0, 0, 0);
    drive(0, 0, 1, 3);
    drive(0, 0, 1, 3);
    drive(0, 1, 1, 3);
    chk("c3_ready_after_close", int'(ballot_ready_o), 0);
    drive(0, 0, 1, 3);
    wait_result(lat);
    chk("c3_ballots", int'(ballots_o), 3);
    chk("c3_winner", int'(winner_o), 3);
    chk("c3_cnt", int'(winner_cnt_o), 3);

    drive(1, 0, 0, 0);
    drive(0, 1, 0, 0);
    for (int i = 0; i < 6; i++) drive(0, 0, 1, 2);
    chk("c4_valid", int'(result_valid_o), 1);
    chk("c4_winner", int'(winner_o), 0);
    chk("c4_cnt", int'(winner_cnt_o), 0);
    chk("c4_tie", int'(tie_o), 1);
    chk("c4_ballots", int'(ballots_o), 0);

    drive(1, 0, 0, 0);
    for (int i = 0; i < 5; i++) drive(0, 0, 1, i % 4);
    chk("c5_ballots_before", int'(ballots_o), 5);
    drive(1, 1, 1, 2);
    chk("c5_ballots", int'(ballots_o), 0);
    chk("c5_busy", int'(busy_o), 1);
    chk("c5_ready", int'(ballot_ready_o), 1);
    drive(0, 0, 1, 2);
    chk("c5_ballots_next", int'(ballots_o), 1);

    drive(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) drive(0, 0, 1, 3);
    drive(0, 0, 0, 0);
    chk("c6_busy_scan", int'(busy_o), 1);
    rst_n = 1'b0;
    #1;
    chk("c6_busy", int'(busy_o), 0);
    chk("c6_ballots", int'(ballots_o), 0);
    chk("c6_valid", int'(result_valid_o), 0);
    chk("c6_cnt", int'(winner_cnt_o), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    drive(0, 0, 0, 0);
    chk("c6_idle_valid", int'(result_valid_o), 0);
    run_case1();

    for (int e = 0; e < 30; e++) begin
      drive(1, 0, 0, 0);
      for (int i = 0; i < 18; i++) begin
        bit v, c, s;
        v = ($urandom % 4) != 0;
        c = ($urandom % 14) == 0;
        s = ($urandom % 50) == 0;
        drive(s, c, v, int'($urandom % 4));
      end
    end

    drive(0, 0, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
